// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between the frame store arbiter and its neighbours.
//   VGA side     : frame_flag, vga_flag/hcount/vcount in; vga_pixel, done_vga out
//   Capture side : write_req/hcount/vcount/pixel in; write_ready out
//   ZBT side     : mem_addr, mem_we_b, mem_data_out, mem_data_drive out; mem_data_in in
// slave is the arbiter's view, master is the view of everything around it.
interface frame_mem_arbiter_if #(
  parameter int unsigned LOG_MEM  = 36,
  parameter int unsigned LOG_ADDR = 19
);
  logic                frame_flag;
  logic                vga_flag;
  logic [9:0]          vga_hcount;
  logic [9:0]          vga_vcount;
  logic [LOG_MEM-1:0]  vga_pixel;
  logic                done_vga;
  logic                write_req;
  logic [9:0]          write_hcount;
  logic [9:0]          write_vcount;
  logic [LOG_MEM-1:0]  write_pixel;
  logic                write_ready;
  logic [LOG_ADDR-1:0] mem_addr;
  logic                mem_we_b;
  logic [LOG_MEM-1:0]  mem_data_out;
  logic                mem_data_drive;
  logic [LOG_MEM-1:0]  mem_data_in;

  modport slave (
    input  frame_flag, vga_flag, vga_hcount, vga_vcount,
    input  write_req, write_hcount, write_vcount, write_pixel,
    input  mem_data_in,
    output vga_pixel, done_vga, write_ready,
    output mem_addr, mem_we_b, mem_data_out, mem_data_drive
  );

  modport master (
    output frame_flag, vga_flag, vga_hcount, vga_vcount,
    output write_req, write_hcount, write_vcount, write_pixel,
    output mem_data_in,
    input  vga_pixel, done_vga, write_ready,
    input  mem_addr, mem_we_b, mem_data_out, mem_data_drive
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Owns the ZBT port: VGA pixel-pair reads at top priority, capture writes
// queued in a 2-entry FIFO and issued in free slots, double-buffered frame
// store with display/write buffers swapped by frame_flag.
// Ports: clock, reset (async, active low), bus (frame_mem_arbiter_if.slave).
module frame_mem_arbiter #(
  parameter int unsigned LOG_MEM        = 36,
  parameter int unsigned LOG_ADDR       = 19,
  parameter int unsigned WORDS_PER_LINE = 320,
  parameter int unsigned FRAME_WORDS    = 153600
) (
  input logic                clock,
  input logic                reset,
  frame_mem_arbiter_if.slave bus
);

  localparam int unsigned H_LIMIT = 2 * WORDS_PER_LINE;
  localparam int unsigned V_LIMIT = FRAME_WORDS / WORDS_PER_LINE;

  typedef struct packed {
    logic [LOG_ADDR-1:0] addr;
    logic [LOG_MEM-1:0]  data;
  } wr_entry_t;

  logic                display_sel;
  wr_entry_t           fifo_q [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  // Read tracking: bit 0 is the issue stage, bit 3 the cycle before return.
  logic [3:0]          rd_v;
  logic [3:0]          rd_ok;
  logic                iss_wr;
  logic [LOG_ADDR-1:0] iss_addr;
  logic [LOG_MEM-1:0]  iss_data;
  logic                wd_v1;
  logic                wd_v2;
  logic [LOG_MEM-1:0]  wd1;
  logic [LOG_MEM-1:0]  wd2;

  logic                rd_ok_c;
  logic                wr_ok_c;
  logic                push_c;
  logic                pop_c;
  logic [1:0]          count_next_c;
  logic [LOG_ADDR-1:0] rd_addr_c;
  logic [LOG_ADDR-1:0] wr_addr_c;

  // base + line*320 + column/2; line*320 built as (line<<8)+(line<<6).
  function automatic logic [LOG_ADDR-1:0] word_addr(input logic       sel,
                                                     input logic [8:0] col,
                                                     input logic [9:0] line);
    logic [LOG_ADDR-1:0] base;
    base = sel ? LOG_ADDR'(FRAME_WORDS) : '0;
    return base + (LOG_ADDR'(line) << 8) + (LOG_ADDR'(line) << 6) + LOG_ADDR'(col);
  endfunction

  function automatic logic in_range(input logic [9:0] col, input logic [9:0] line);
    return (32'(col) < H_LIMIT) && (32'(line) < V_LIMIT);
  endfunction

  // Request decode and FIFO occupancy; a VGA request claims the slot.
  always_comb begin
    rd_ok_c      = in_range(bus.vga_hcount, bus.vga_vcount);
    wr_ok_c      = in_range(bus.write_hcount, bus.write_vcount);
    rd_addr_c    = word_addr(display_sel, bus.vga_hcount[9:1], bus.vga_vcount);
    wr_addr_c    = word_addr(~display_sel, bus.write_hcount[9:1], bus.write_vcount);
    push_c       = bus.write_req & bus.write_ready & wr_ok_c;
    pop_c        = ~bus.vga_flag & (count != 2'd0);
    count_next_c = count + 2'(push_c) - 2'(pop_c);
  end

  // Buffer select, write FIFO and slot issue stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      display_sel     <= 1'b0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      count           <= 2'd0;
      bus.write_ready <= 1'b0;
      rd_v            <= '0;
      rd_ok           <= '0;
      iss_wr          <= 1'b0;
      iss_addr        <= '0;
      iss_data        <= '0;
    end else begin
      if (bus.frame_flag) display_sel <= ~display_sel;
      if (push_c) begin
        fifo_q[wr_ptr] <= '{addr: wr_addr_c, data: bus.write_pixel};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop_c) rd_ptr <= ~rd_ptr;
      count           <= count_next_c;
      bus.write_ready <= (count_next_c < 2'd2);
      rd_v            <= {rd_v[2:0], bus.vga_flag};
      rd_ok           <= {rd_ok[2:0], bus.vga_flag & rd_ok_c};
      if (bus.vga_flag) begin
        iss_wr   <= 1'b0;
        iss_addr <= rd_addr_c;
      end else if (pop_c) begin
        iss_wr   <= 1'b1;
        iss_addr <= fifo_q[rd_ptr].addr;
        iss_data <= fifo_q[rd_ptr].data;
      end else begin
        iss_wr <= 1'b0;
      end
    end
  end

  // ZBT command/data stage and VGA return stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.mem_addr       <= '0;
      bus.mem_we_b       <= 1'b1;
      bus.mem_data_out   <= '0;
      bus.mem_data_drive <= 1'b0;
      bus.vga_pixel      <= '0;
      bus.done_vga       <= 1'b0;
      wd_v1              <= 1'b0;
      wd_v2              <= 1'b0;
      wd1                <= '0;
      wd2                <= '0;
    end else begin
      if (rd_v[0] && rd_ok[0]) begin
        bus.mem_addr <= iss_addr;
        bus.mem_we_b <= 1'b1;
      end else if (iss_wr) begin
        bus.mem_addr <= iss_addr;
        bus.mem_we_b <= 1'b0;
      end else begin
        bus.mem_we_b <= 1'b1;
      end
      // Write data trails its address cycle by two clocks.
      wd_v1              <= iss_wr;
      wd1                <= iss_data;
      wd_v2              <= wd_v1;
      wd2                <= wd1;
      bus.mem_data_drive <= wd_v2;
      if (wd_v2) bus.mem_data_out <= wd2;
      bus.done_vga <= rd_v[3];
      if (rd_v[3]) bus.vga_pixel <= rd_ok[3] ? bus.mem_data_in : '0;
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter: stimulus pushes expected ZBT
// accesses and VGA returns; negedge monitors pop and compare.
module tb_frame_mem_arbiter;

  logic clock = 1'b0;
  logic reset;

  frame_mem_arbiter_if #(.LOG_MEM(36), .LOG_ADDR(19)) bus ();

  frame_mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [18:0] addr; logic ok; } rd_addr_t;
  typedef struct { int cyc; logic [35:0] data; } rd_data_t;

  rd_addr_t    ra_q [$];
  rd_data_t    rd_q [$];
  logic [18:0] wa_q [$];
  logic [35:0] wd_q [$];
  int          drv_q [$];

  logic disp = 1'b0;
  logic last_acc;
  logic saw_not_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [18:0] model_addr(input logic sel, input int h, input int v);
    int base;
    base = sel ? 153600 : 0;
    return 19'(base + v * 320 + h / 2);
  endfunction

  function automatic logic [35:0] zbt_word(input logic [18:0] a);
    if (a == 19'd642) return 36'h123456789;
    return {17'h12C3D, a};
  endfunction

  // ZBT model: data for an address presented after edge E is valid after E+2.
  logic [18:0] z1, z2;
  always @(posedge clock) begin
    z1 <= bus.mem_addr;
    z2 <= z1;
  end
  assign bus.mem_data_in = zbt_word(z2);

  // One cycle of stimulus; expectations are pushed before the sampling edge.
  task automatic drive(input logic vf, input int vh, input int vv,
                       input logic wr, input int wh, input int wv,
                       input logic [35:0] wd, input logic ff);
    logic        ok;
    logic [18:0] a;
    bus.vga_flag     = vf;
    bus.vga_hcount   = 10'(vh);
    bus.vga_vcount   = 10'(vv);
    bus.write_req    = wr;
    bus.write_hcount = 10'(wh);
    bus.write_vcount = 10'(wv);
    bus.write_pixel  = wd;
    bus.frame_flag   = ff;
    last_acc = wr && bus.write_ready;
    if (wr && !bus.write_ready) saw_not_ready = 1'b1;
    if (vf) begin
      ok = (vh < 640) && (vv < 480);
      a  = model_addr(disp, vh, vv);
      ra_q.push_back('{cyc + 2, a, ok});
      rd_q.push_back('{cyc + 5, ok ? zbt_word(a) : 36'h0});
    end
    if (last_acc && wh < 640 && wv < 480) begin
      wa_q.push_back(model_addr(!disp, wh, wv));
      wd_q.push_back(wd);
    end
    if (ff) disp = !disp;
    @(posedge clock);
    #1;
    bus.vga_flag   = 1'b0;
    bus.write_req  = 1'b0;
    bus.frame_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 0, 0, 36'h0, 1'b0);
  endtask

  // Monitors: read slots, write slots, write data phase, VGA returns.
  rd_addr_t    ea;
  rd_data_t    ed;
  logic [18:0] prev_addr;
  int          dc;
  always @(negedge clock) begin
    if (reset) begin
      if (ra_q.size() > 0 && ra_q[0].cyc == cyc) begin
        ea = ra_q.pop_front();
        check("rd_slot_we_b", 64'(bus.mem_we_b), 64'd1);
        check("rd_addr", 64'(bus.mem_addr), 64'(ea.ok ? ea.addr : prev_addr));
      end
      if (bus.mem_we_b == 1'b0) begin
        if (wa_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr %0h with nothing queued (cycle %0d)", bus.mem_addr, cyc);
        end else begin
          check("wr_addr", 64'(bus.mem_addr), 64'(wa_q.pop_front()));
        end
        drv_q.push_back(cyc + 2);
      end
      if (bus.mem_data_drive) begin
        if (drv_q.size() == 0 || wd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_drive: data %0h (cycle %0d)", bus.mem_data_out, cyc);
        end else begin
          dc = drv_q.pop_front();
          check("wr_data_cycle", 64'(cyc), 64'(dc));
          check("wr_data", 64'(bus.mem_data_out), 64'(wd_q.pop_front()));
        end
      end
      if (bus.done_vga) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: pixel %0h (cycle %0d)", bus.vga_pixel, cyc);
        end else begin
          ed = rd_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(ed.cyc));
          check("vga_pixel", 64'(bus.vga_pixel), 64'(ed.data));
        end
      end
    end
    prev_addr = bus.mem_addr;
  end

  task automatic clear_queues();
    ra_q.delete(); rd_q.delete(); wa_q.delete(); wd_q.delete(); drv_q.delete();
    disp = 1'b0;
  endtask

  initial begin
    int k;
    reset            = 1'b0;
    bus.frame_flag   = 1'b0;
    bus.vga_flag     = 1'b0;
    bus.vga_hcount   = '0;
    bus.vga_vcount   = '0;
    bus.write_req    = 1'b0;
    bus.write_hcount = '0;
    bus.write_vcount = '0;
    bus.write_pixel  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_vga_pixel", 64'(bus.vga_pixel), 64'd0);
    check("rst_done_vga", 64'(bus.done_vga), 64'd0);
    check("rst_write_ready", 64'(bus.write_ready), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_we_b", 64'(bus.mem_we_b), 64'd1);
    check("rst_mem_data_out", 64'(bus.mem_data_out), 64'd0);
    check("rst_mem_data_drive", 64'(bus.mem_data_drive), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("write_ready_after_reset", 64'(bus.write_ready), 64'd1);

    // Basic read: (5,2) in buffer 0 -> 642.
    drive(1'b1, 5, 2, 1'b0, 0, 0, 36'h0, 1'b0);
    idle(6);

    // Basic write: (0,0) lands in buffer 1 -> 153600.
    drive(1'b0, 0, 0, 1'b1, 0, 0, 36'hABC, 1'b0);
    idle(6);

    // Reads every 4 cycles with write_req held; hold each write until accepted.
    k = 0;
    for (int i = 0; i < 24; i++) begin
      drive((i % 4) == 0, 8 * i + 3, 100 + i, 1'b1, 4 * k + 1, 10 + k,
            36'h5_0000_0000 + 36'(k), 1'b0);
      if (last_acc) k++;
    end
    check("write_ready_deasserted", 64'(saw_not_ready), 64'd1);
    idle(8);

    // Queued write behind a read in the same cycle.
    drive(1'b0, 0, 0, 1'b1, 2, 3, 36'h7_7777_0001, 1'b0);
    drive(1'b1, 6, 7, 1'b1, 30, 40, 36'h7_7777_0002, 1'b0);
    idle(8);

    // Buffer swap, then read/write on the new buffers; swap again with a read.
    drive(1'b0, 0, 0, 1'b0, 0, 0, 36'h0, 1'b1);
    drive(1'b1, 0, 0, 1'b1, 8, 1, 36'h9_0000_0324, 1'b0);
    idle(3);
    drive(1'b1, 20, 1, 1'b0, 0, 0, 36'h0, 1'b1);
    idle(3);
    drive(1'b1, 0, 0, 1'b1, 639, 479, 36'h9_0000_0FFF, 1'b0);
    idle(8);

    // Out of range: read at vcount 480, write at hcount 640 is dropped.
    drive(1'b1, 10, 480, 1'b1, 640, 5, 36'hD_EAD0_0000, 1'b0);
    idle(3);
    drive(1'b1, 638, 479, 1'b1, 4, 1023, 36'hD_EAD0_0001, 1'b0);
    idle(8);

    // Reset with a read in flight and a write queued: both are discarded.
    drive(1'b1, 4, 4, 1'b1, 12, 12, 36'hB_AD00_0000, 1'b0);
    reset = 1'b0;
    clear_queues();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(10);
    drive(1'b1, 5, 2, 1'b0, 0, 0, 36'h0, 1'b0);

    for (int i = 0; i < 50; i++) begin
      if (ra_q.size() + rd_q.size() + wa_q.size() + wd_q.size() + drv_q.size() == 0) break;
      @(posedge clock);
    end
    #1;
    check("queues_drained",
          64'(ra_q.size() + rd_q.size() + wa_q.size() + wd_q.size() + drv_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Sits directly upstream of the VGA output stage and owns the ZBT SRAM port.
- Serves VGA pixel-pair read requests at top priority, addressed by the VGA stage's latched hcount/vcount, and returns 36-bit words (two packed 18-bit YCrCb pixels).
- Interleaves pixel-pair writes from the capture side into a double-buffered frame store; the displayed and written buffers swap on frame_flag.

Parameters:
LOG_MEM, 36, memory word width (two 18-bit YCrCb pixels)
LOG_ADDR, 19, ZBT address width
WORDS_PER_LINE, 320, memory words per 640-pixel line
FRAME_WORDS, 153600, words per frame (320*480); base offset of buffer 1

Ports:
clock  in  1  system clock (65 MHz domain, same as VGA request logic)
reset  in  1  asynchronous, active-low reset
frame_flag  in  1  one-cycle pulse; toggles displayed/written buffer select
vga_flag  in  1  VGA read request, one cycle, at most 1 in every 4 cycles
vga_hcount  in  10  pixel column of request (bit 0 ignored)
vga_vcount  in  10  line of request
vga_pixel  out  LOG_MEM  returned pixel pair
done_vga  out  1  one-cycle pulse: vga_pixel updated
write_req  in  1  write request
write_hcount  in  10  pixel column of write (bit 0 ignored)
write_vcount  in  10  line of write
write_pixel  in  LOG_MEM  pixel pair to store
write_ready  out  1  FIFO can accept a write this cycle
mem_addr  out  LOG_ADDR  ZBT address
mem_we_b  out  1  ZBT write enable, active low
mem_data_out  out  LOG_MEM  ZBT write data
mem_data_drive  out  1  high: tristate driver enables mem_data_out
mem_data_in  in  LOG_MEM  ZBT read data

Behaviour:
- Reset (reset low, asynchronous): vga_pixel=0, done_vga=0, write_ready=0, mem_addr=0, mem_we_b=1, mem_data_out=0, mem_data_drive=0.
- Reset also empties the write FIFO, sets display_sel=0 and flushes all pipeline stages.
- write_ready rises on the first clock edge after reset deasserts.
- Address: addr = base + (vcount<<8) + (vcount<<6) + hcount[9:1], computed in LOG_ADDR bits, no overflow possible in range.
  - VGA read base: display_sel ? FRAME_WORDS : 0.
  - Write base: the opposite buffer, evaluated when the write enters the FIFO.
- Out of range (hcount>=640 or vcount>=480):
  - Read: no memory cycle is issued; done_vga still pulses at normal latency with vga_pixel=0.
  - Write: accepted and dropped without a memory cycle.
- Slot arbitration, one memory op per cycle:
  - vga_flag high: slot S is a read (mem_we_b=1 at edge S+1).
  - Otherwise, FIFO non-empty: head write is issued (mem_we_b=0, mem_addr=head addr at edge S+1) and popped.
  - Otherwise: idle, mem_we_b=1, mem_addr holds its value.
- Read latency (vga_flag sampled high at edge 0):
  - mem_addr valid after edge 1.
  - mem_data_in valid after edge 3 (ZBT 2-cycle pipeline).
  - Edge 4: vga_pixel <= mem_data_in, done_vga=1 for exactly one cycle.
  - vga_pixel holds until the next done_vga.
  - Back-to-back reads are legal: one in flight per cycle, fully pipelined.
- Write data: mem_data_out and mem_data_drive=1 are presented 2 cycles after the write address cycle, for one cycle. mem_data_drive=0 at all other times.
- Write FIFO:
  - 2 entries; each entry holds the computed address and the data.
  - write_ready = (count<2), registered.
  - A write is accepted on an edge where write_req and write_ready are both high.
  - Push and pop on the same edge leave count unchanged.
  - write_req while write_ready=0 is ignored; the requester must hold.
- Starvation bound: VGA takes at most 1 of every 4 slots, so sustained write throughput is at least 3 per 4 cycles.
- frame_flag: display_sel toggles on the edge where frame_flag is sampled.
  - Reads/writes already captured keep their computed addresses.
  - Only subsequent requests use the new select.
- Simultaneous vga_flag and frame_flag: the read uses the pre-toggle display_sel.
- Reset mid-operation: in-flight reads produce no done_vga, and queued writes are discarded.

Test Plan:
- Reset then vga_flag with hcount=5, vcount=2, display_sel=0 -> mem_addr=642 after edge 1; mem_data_in=36'h123456789 at cycle 3 -> done_vga pulse at edge 4 with vga_pixel=36'h123456789.
- Write hcount=0, vcount=0, pixel=36'hABC with no reads -> mem_we_b=0, mem_addr=153600 next cycle; mem_data_out=36'hABC with mem_data_drive=1 two cycles later.
- vga_flag every 4 cycles plus write_req held high continuously -> every read serviced at latency 4; no slot ever carries two ops; write_ready deasserts when 2 writes are queued.
- vga_flag and write pending in the same cycle -> read issued first; the write is issued next cycle at the correct address.
- frame_flag pulse, then read at hcount=0, vcount=0 -> mem_addr=153600; the following write targets base 0.
- Read with vcount=480 -> no address cycle (mem_we_b stays 1, mem_addr unchanged); done_vga at edge 4 with vga_pixel=0. Assert reset with a read in flight -> no done_vga.
